seven_seg_capture_decoder: RTL

- Receive side of the multiplexed seven-segment display bus (seg_sel / seg_data).
- Samples the scanned bus, waits until each scan slot is stable, then decodes the segment pattern back to a 4-bit digit and stores it per digit position.
- Used for display loopback self-test and for monitoring what the counter datapath actually drives onto the display.
- Emits one valid/ready event per captured digit.

---
 rtl/seven_seg_capture_decoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_capture_decoder
//
// Receive side of the multiplexed seven-segment display bus. The scanned
// {seg_sel, seg_data} bus is synchronised. Each scan slot is captured once it
// has been stable for STABLE_CYCLES samples. The segment pattern is decoded
// back to a 4-bit digit and stored per digit position. Each captured digit
// produces one valid/ready event.
//
// Optional build macro: SEG_CAPTURE_ERR_CNT_EN adds the err_count output. It
// counts captures that flagged sel_err or bad_pat and saturates at 255.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   seg_sel     digit select from the display bus, one-hot active-high
//   seg_data    segment bus: bit0..6 = a..g, bit7 = dp
//   out_valid   capture event pending
//   out_ready   consumer accepts the event when out_valid & out_ready
//   out_idx     digit position of the pending event
//   out_digit   decoded value of the pending event (4'hF = unrecognised)
//   out_dp      dp bit of the pending event
//   digits      last decoded value per position; digit i at [4i+3:4i]
//   dps         last dp bit per position
//   overrun     sticky: capture while an unaccepted event was pending
//   sel_err     sticky: stable multi-hot seg_sel seen
//   bad_pat     sticky: stable segment pattern not in the decode table
//   err_count   (SEG_CAPTURE_ERR_CNT_EN only) saturating error-capture count
//   clr_status  synchronous clear of the sticky flags and err_count
// -----------------------------------------------------------------------------
module seven_seg_capture_decoder #(
    parameter int NUM_DIGITS    = 5,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     seg_sel,
    input  logic [7:0]                seg_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_idx,
    output logic [3:0]                out_digit,
    output logic                      out_dp,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dps,
    output logic                      overrun,
    output logic                      sel_err,
    output logic                      bad_pat,
`ifdef SEG_CAPTURE_ERR_CNT_EN
    output logic [7:0]                err_count,
`endif
    input  logic                      clr_status
);

    localparam int         BW          = NUM_DIGITS + 8;
    localparam logic [7:0] STABLE_SAT  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [BW-1:0]         sync_1;
    logic [BW-1:0]         sync_s;
    logic [BW-1:0]         prev_s;
    logic [7:0]            stab_cnt;
    logic                  armed;

    logic                  same;
    logic                  capture;
    logic [NUM_DIGITS-1:0] cap_sel;
    logic [7:0]            cap_data;
    logic                  sel_one_hot;
    logic                  sel_multi;
    logic [2:0]            cap_idx;
    logic [3:0]            cap_digit;
    logic                  cap_bad;

    logic                  set_sel_err;
    logic                  set_bad_pat;
    logic                  set_overrun;
    logic                  cap_event;

    assign cap_sel  = sync_s[BW-1:8];
    assign cap_data = sync_s[7:0];
    assign same     = (sync_s == prev_s);

    // The capture fires on the edge where the counter reaches STABLE_CYCLES.
    // The event registers load on that same edge, so the total latency is
    // STABLE_CYCLES + 3 edges.
    assign capture  = same && armed && (stab_cnt == STABLE_LAST);

    assign sel_one_hot = $onehot(cap_sel);
    assign sel_multi   = !$onehot0(cap_sel);

    assign cap_event   = capture && sel_one_hot;
    assign set_sel_err = capture && sel_multi;
    assign set_bad_pat = cap_event && cap_bad;
    assign set_overrun = cap_event && out_valid && !out_ready;

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) cap_idx = i[2:0];
        end
    end

    always_comb begin
        cap_digit = 4'hF;
        cap_bad   = 1'b0;
        case (cap_data[6:0])
            7'h3F:   cap_digit = 4'd0;
            7'h06:   cap_digit = 4'd1;
            7'h5B:   cap_digit = 4'd2;
            7'h4F:   cap_digit = 4'd3;
            7'h66:   cap_digit = 4'd4;
            7'h6D:   cap_digit = 4'd5;
            7'h7D:   cap_digit = 4'd6;
            7'h07:   cap_digit = 4'd7;
            7'h7F:   cap_digit = 4'd8;
            7'h6F:   cap_digit = 4'd9;
            default: begin
                cap_digit = 4'hF;
                cap_bad   = 1'b1;
            end
        endcase
    end

    // Synchroniser and stability tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= '0;
            sync_s   <= '0;
            prev_s   <= '0;
            stab_cnt <= '0;
            armed    <= 1'b1;
        end else begin
            sync_1 <= {seg_sel, seg_data};
            sync_s <= sync_1;
            prev_s <= sync_s;
            if (!same) begin
                stab_cnt <= '0;
                armed    <= 1'b1;
            end else begin
                if (stab_cnt != STABLE_SAT) stab_cnt <= stab_cnt + 8'd1;
                if (capture) armed <= 1'b0;
            end
        end
    end

    // Event register with valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_digit <= '0;
            out_dp    <= 1'b0;
        end else if (cap_event && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_idx   <= cap_idx;
            out_digit <= cap_digit;
            out_dp    <= cap_data[7];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-position store; updated even when the event itself is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            dps    <= '0;
        end else if (cap_event) begin
            digits[{cap_idx, 2'b00} +: 4] <= cap_digit;
            dps[cap_idx]                  <= cap_data[7];
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            sel_err <= 1'b0;
            bad_pat <= 1'b0;
        end else begin
            overrun <= (overrun && !clr_status) || set_overrun;
            sel_err <= (sel_err && !clr_status) || set_sel_err;
            bad_pat <= (bad_pat && !clr_status) || set_bad_pat;
        end
    end

`ifdef SEG_CAPTURE_ERR_CNT_EN
    // Unlike the flags, a clear wins over an increment here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_status) begin
            err_count <= '0;
        end else if ((set_sel_err || set_bad_pat) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
